// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between a CPU and a DMA requester.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority, cpu over dma.
module dmem_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [1:0]  cpu_width_i,
  input  logic        cpu_sext_i,
  output logic        cpu_gnt_o,
  output logic        cpu_done_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        dma_req_i,
  input  logic        dma_we_i,
  input  logic [31:0] dma_addr_i,
  input  logic [31:0] dma_wdata_i,
  input  logic [1:0]  dma_width_i,
  input  logic        dma_sext_i,
  output logic        dma_gnt_o,
  output logic        dma_done_o,
  output logic [31:0] dma_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  output logic [1:0]  mem_width_o,
  output logic        mem_sign_extend_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_result_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        owner_dma_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  width_q;
  logic        sext_q;
  logic [31:0] cpu_rdata_q;
  logic [31:0] dma_rdata_q;
  logic        cpu_done_q;
  logic        dma_done_q;

  logic        win_dma_d;
  logic        arb_en;
  logic        mem_en;
  logic        final_beat;

`ifdef DMEM_ARB_RR_EN
  logic last_dma_q;
  // On contention the requester that did not win last time goes first.
  assign win_dma_d = dma_req_i && (!cpu_req_i || !last_dma_q);
`else
  assign win_dma_d = dma_req_i && !cpu_req_i;
`endif

  // Grants and the memory port are gated by rst_i so a reset cycle never
  // issues a grant or a write strobe, even mid-access.
  assign arb_en     = (state_q == IDLE) && !rst_i;
  assign cpu_gnt_o  = arb_en && cpu_req_i && !win_dma_d;
  assign dma_gnt_o  = arb_en && win_dma_d;
  assign final_beat = (state_q == BUSY) && (cnt_q == 4'd0);
  assign mem_en     = (state_q == BUSY) && !rst_i;

  assign mem_addr_o        = mem_en ? addr_q  : '0;
  assign mem_data_o        = mem_en ? wdata_q : '0;
  assign mem_width_o       = mem_en ? width_q : '0;
  assign mem_sign_extend_o = mem_en && sext_q;
  assign mem_write_o       = mem_en && final_beat && we_q;

  assign busy_o      = (state_q != IDLE);
  assign cpu_done_o  = cpu_done_q;
  assign dma_done_o  = dma_done_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign dma_rdata_o = dma_rdata_q;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      owner_dma_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      sext_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_done_q  <= 1'b0;
      dma_done_q  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      last_dma_q  <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_gnt_o || dma_gnt_o) begin
            owner_dma_q <= win_dma_d;
            we_q        <= win_dma_d ? dma_we_i    : cpu_we_i;
            addr_q      <= win_dma_d ? dma_addr_i  : cpu_addr_i;
            wdata_q     <= win_dma_d ? dma_wdata_i : cpu_wdata_i;
            width_q     <= win_dma_d ? dma_width_i : cpu_width_i;
            sext_q      <= win_dma_d ? dma_sext_i  : cpu_sext_i;
            cnt_q       <= 4'(ACCESS_CYCLES - 1);
            state_q     <= BUSY;
`ifdef DMEM_ARB_RR_EN
            last_dma_q  <= win_dma_d;
`endif
          end
        end
        BUSY: begin
          if (final_beat) begin
            state_q <= DONE;
            if (owner_dma_q) dma_done_q <= 1'b1;
            else             cpu_done_q <= 1'b1;
            if (!we_q) begin
              if (owner_dma_q) dma_rdata_q <= mem_result_i;
              else             cpu_rdata_q <= mem_result_i;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          cpu_done_q <= 1'b0;
          dma_done_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: stimulus pushes expected grant/write/done events,
// a negedge monitor pops and compares them; a small byte memory models the data port.
module tb_dmem_arbiter;

  localparam int ACC = 2;
  localparam int K_CPU_GNT = 0, K_DMA_GNT = 1, K_CPU_DONE = 2, K_DMA_DONE = 3, K_WRITE = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i, cpu_sext_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic [1:0]  cpu_width_i;
  logic        dma_req_i, dma_we_i, dma_sext_i;
  logic [31:0] dma_addr_i, dma_wdata_i;
  logic [1:0]  dma_width_i;
  logic        cpu_gnt_o, cpu_done_o, dma_gnt_o, dma_done_o;
  logic [31:0] cpu_rdata_o, dma_rdata_o;
  logic [31:0] mem_addr_o, mem_data_o, mem_result_i;
  logic [1:0]  mem_width_o;
  logic        mem_sign_extend_o, mem_write_o, busy_o;

  dmem_arbiter #(.ACCESS_CYCLES(ACC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_width_i(cpu_width_i), .cpu_sext_i(cpu_sext_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
    .dma_wdata_i(dma_wdata_i), .dma_width_i(dma_width_i), .dma_sext_i(dma_sext_i),
    .dma_gnt_o(dma_gnt_o), .dma_done_o(dma_done_o), .dma_rdata_o(dma_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_sign_extend_o(mem_sign_extend_o), .mem_write_o(mem_write_o),
    .mem_result_i(mem_result_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Little-endian byte memory, read combinationally from the port.
  logic [7:0] mem [0:255];
  logic [7:0] ra;
  always_comb begin
    ra = mem_addr_o[7:0];
    mem_result_i = '0;
    case (mem_width_o)
      2'd0: mem_result_i = mem_sign_extend_o ? {{24{mem[ra][7]}}, mem[ra]} : {24'd0, mem[ra]};
      2'd1: mem_result_i = mem_sign_extend_o ?
                           {{16{mem[ra + 8'd1][7]}}, mem[ra + 8'd1], mem[ra]} :
                           {16'd0, mem[ra + 8'd1], mem[ra]};
      default: mem_result_i = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};
    endcase
  end

  always @(posedge clk_i) begin
    if (mem_write_o) begin
      mem[mem_addr_o[7:0]] <= mem_data_o[7:0];
      if (mem_width_o != 2'd0) mem[mem_addr_o[7:0] + 8'd1] <= mem_data_o[15:8];
      if (mem_width_o == 2'd2) begin
        mem[mem_addr_o[7:0] + 8'd2] <= mem_data_o[23:16];
        mem[mem_addr_o[7:0] + 8'd3] <= mem_data_o[31:24];
      end
    end
  end

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [31:0] m_cpu = '0, m_dma = '0;
  bit   last_dma = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic string kname(input int k);
    case (k)
      K_CPU_GNT:  return "cpu_gnt";
      K_DMA_GNT:  return "dma_gnt";
      K_CPU_DONE: return "cpu_done";
      K_DMA_DONE: return "dma_done";
      default:    return "mem_write";
    endcase
  endfunction

  task automatic observe(input int kind, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected %s at cycle %0d (a=%h b=%h)", kname(kind), cyc, a, b);
    end else begin
      e = sb.pop_front();
      check({kname(e.kind), " kind/cycle"}, {32'(kind), 32'(cyc)}, {32'(e.kind), 32'(e.cyc)});
      check({kname(e.kind), " data"}, {a, b}, {e.a, e.b});
    end
  endtask

  always @(negedge clk_i) begin
    if (cpu_gnt_o)   observe(K_CPU_GNT, '0, '0);
    if (dma_gnt_o)   observe(K_DMA_GNT, '0, '0);
    if (mem_write_o) observe(K_WRITE, mem_addr_o, mem_data_o);
    if (cpu_done_o)  observe(K_CPU_DONE, cpu_rdata_o, dma_rdata_o);
    if (dma_done_o)  observe(K_DMA_DONE, cpu_rdata_o, dma_rdata_o);
  end

  task automatic next();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit is_dma, input bit req, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] width, input bit sext);
    if (is_dma) begin
      dma_req_i = req; dma_we_i = we; dma_addr_i = addr;
      dma_wdata_i = wdata; dma_width_i = width; dma_sext_i = sext;
    end else begin
      cpu_req_i = req; cpu_we_i = we; cpu_addr_i = addr;
      cpu_wdata_i = wdata; cpu_width_i = width; cpu_sext_i = sext;
    end
  endtask

  // Expected events of one access granted at cycle t.
  task automatic push_txn(input bit is_dma, input int t, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] result);
    sb.push_back('{is_dma ? K_DMA_GNT : K_CPU_GNT, t, 32'd0, 32'd0});
    if (we) sb.push_back('{K_WRITE, t + ACC, addr, wdata});
    else if (is_dma) m_dma = result;
    else m_cpu = result;
    sb.push_back('{is_dma ? K_DMA_DONE : K_CPU_DONE, t + ACC + 1, m_cpu, m_dma});
    last_dma = is_dma;
  endtask

  // One access from an idle arbiter; fields are scrambled after the grant and,
  // with poke, the other requester raises req for one BUSY cycle only.
  task automatic access(input bit is_dma, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] width, input bit sext,
                        input logic [31:0] result, input bit poke);
    int t;
    t = cyc;
    push_txn(is_dma, t, we, addr, wdata, result);
    drive(is_dma, 1'b1, we, addr, wdata, width, sext);
    next();
    drive(is_dma, 1'b0, !we, ~addr, ~wdata, 2'd0, !sext);
    if (poke) drive(!is_dma, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
    @(negedge clk_i);
    check("mem_addr first busy cycle", 64'(mem_addr_o), 64'(addr));
    check("busy_o during access", 64'(busy_o), 64'd1);
    next();
    if (poke) drive(!is_dma, 1'b0, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
    @(negedge clk_i);
    check("mem_addr final busy cycle", 64'(mem_addr_o), 64'(addr));
    check("mem_width final busy cycle", 64'(mem_width_o), 64'(width));
    next();
    @(negedge clk_i);
    check("mem_addr zero in DONE", 64'(mem_addr_o), 64'd0);
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h10] <= 8'hEF; mem[8'h11] <= 8'hBE; mem[8'h12] <= 8'hAD; mem[8'h13] <= 8'hDE;
    mem[8'h30] <= 8'h80;
    rst_i = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'd0, 1'b0);
    next();
    next();
    @(negedge clk_i);
    check("cpu_gnt held low in reset", 64'(cpu_gnt_o), 64'd0);
    next();
    cpu_req_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset busy_o", 64'(busy_o), 64'd0);
    check("reset mem port", {mem_addr_o, mem_data_o}, 64'd0);
    check("reset mem ctl", {61'd0, mem_width_o, mem_write_o}, 64'd0);
    check("reset done", {62'd0, cpu_done_o, dma_done_o}, 64'd0);
    check("reset rdata", {cpu_rdata_o, dma_rdata_o}, 64'd0);
    next();

    access(1'b0, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0);
    access(1'b1, 1'b1, 32'h20, 32'h12345678, 2'd2, 1'b0, 32'd0, 1'b0);
    access(1'b0, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0, 32'h12345678, 1'b0);
    access(1'b0, 1'b0, 32'h30, 32'd0, 2'd0, 1'b1, 32'hFFFFFF80, 1'b0);
    access(1'b0, 1'b0, 32'h30, 32'd0, 2'd0, 1'b0, 32'h00000080, 1'b0);
    access(1'b1, 1'b0, 32'h12, 32'd0, 2'd1, 1'b1, 32'hFFFFDEAD, 1'b0);
    access(1'b1, 1'b1, 32'h50, 32'hA5A5A5A5, 2'd2, 1'b0, 32'd0, 1'b1);
    access(1'b1, 1'b0, 32'h53, 32'd0, 2'd0, 1'b0, 32'h000000A5, 1'b0);

    // Reset one cycle into a cpu store: the access is abandoned.
    begin
      int t;
      t = cyc;
      sb.push_back('{K_CPU_GNT, t, 32'd0, 32'd0});
      drive(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2'd2, 1'b0);
      next();
      cpu_req_i = 1'b0;
      rst_i = 1'b1;
      next();
      rst_i = 1'b0;
      m_cpu = '0;
      m_dma = '0;
      last_dma = 1'b1;
      @(negedge clk_i);
      check("busy_o after mid-access reset", 64'(busy_o), 64'd0);
      check("rdata cleared by reset", {cpu_rdata_o, dma_rdata_o}, 64'd0);
      next();
      next();
      @(negedge clk_i);
      check("memory untouched by aborted store",
            {32'd0, mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}, 64'd0);
      next();
    end

    // Both requesters held through three full access periods.
    begin
      int  t0;
      bit  w;
      t0 = cyc;
      for (int i = 0; i < 3; i++) begin
`ifdef DMEM_ARB_RR_EN
        w = !last_dma;
`else
        w = 1'b0;
`endif
        push_txn(w, t0 + i * (ACC + 2), 1'b0, w ? 32'h20 : 32'h10, 32'd0,
                 w ? 32'h12345678 : 32'hDEADBEEF);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'd0, 2'd2, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 2'd2, 1'b0);
      repeat (3 * (ACC + 2) - 1) next();
      cpu_req_i = 1'b0;
      dma_req_i = 1'b0;
      repeat (4) next();
    end

    @(negedge clk_i);
    check("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, SHALL set memory access length in cycles; legal range 1..15.
REQ-002 clk_i  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 cpu_req_i / dma_req_i  input  1  SHALL be per-requester access requests.
REQ-005 cpu_we_i / dma_we_i  input  1  SHALL mean 1 = store, 0 = load.
REQ-006 cpu_addr_i / dma_addr_i  input  32  SHALL be the byte address.
REQ-007 cpu_wdata_i / dma_wdata_i  input  32  SHALL be the store data.
REQ-008 cpu_width_i / dma_width_i  input  2  SHALL be the access width: 0 = byte, 1 = half, 2 = word.
REQ-009 cpu_sext_i / dma_sext_i  input  1  SHALL select load sign-extension.
REQ-010 cpu_gnt_o / dma_gnt_o  output  1  SHALL pulse for one cycle when the request is accepted.
REQ-011 cpu_done_o / dma_done_o  output  1  SHALL pulse for one cycle when the access completes.
REQ-012 cpu_rdata_o / dma_rdata_o  output  32  SHALL hold the requester's last load result.
REQ-013 mem_addr_o 32, mem_data_o 32, mem_width_o 2, mem_sign_extend_o 1, mem_write_o 1  outputs  SHALL drive the shared data memory port.
REQ-014 mem_result_i  input  32  SHALL be the memory read data (combinational from mem_addr_o).
REQ-015 busy_o  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 IDLE with no request SHALL remain in IDLE.
REQ-018 IDLE with any request SHALL select a winner, assert its gnt_o combinationally that cycle, latch its we/addr/wdata/width/sext and owner at the clock edge, and move to BUSY with counter = ACCESS_CYCLES-1.
REQ-019 In BUSY, the counter SHALL decrement each cycle; at counter 0 the state SHALL move to DONE.
REQ-020 In BUSY, mem_* outputs SHALL drive the latched fields, except mem_write_o.
REQ-021 mem_write_o SHALL be high only in the final BUSY cycle of a store (exactly one write strobe per store).
REQ-022 In the final BUSY cycle of a load, the owner's rdata register SHALL capture mem_result_i; the other requester's rdata SHALL be unchanged.
REQ-023 A store SHALL leave both rdata registers unchanged.
REQ-024 DONE SHALL assert the owner's done_o for exactly one cycle, then return to IDLE; no arbitration SHALL occur in DONE.
REQ-025 Timing: request-to-done latency SHALL be ACCESS_CYCLES+1 cycles; back-to-back period SHALL be ACCESS_CYCLES+2 cycles.
REQ-026 Outside BUSY, all mem_* outputs SHALL be 0.
REQ-027 A requester SHALL hold req and its fields stable until gnt; after gnt, changes SHALL be ignored until the next arbitration.
REQ-028 A request withdrawn before gnt SHALL cause no access.
REQ-029 A requester still asserting req in DONE SHALL be treated as a new request in the following IDLE.
REQ-030 When only one request is present, it SHALL always win.

Reset
REQ-031 On rst_i: state = IDLE, counter = 0, all gnt/done/mem_* outputs = 0, busy_o = 0, both rdata = 0, last-grant = dma.
REQ-032 Reset asserted mid-access SHALL abort it: no further mem_write_o, no done_o, and the aborted rdata capture SHALL not occur.

Configuration
REQ-033 Macro DMEM_ARB_RR_EN defined: simultaneous requests SHALL be granted round-robin, with the requester not granted last winning; last-grant SHALL update on each gnt.
REQ-034 Macro DMEM_ARB_RR_EN undefined: simultaneous requests SHALL be granted by fixed priority, cpu over dma; the last-grant register SHALL be absent.

Verification (ACCESS_CYCLES=2)
REQ-035 cpu load at 0x10, memory word 0xDEADBEEF -> cpu_gnt_o at T, mem_addr_o = 0x10 at T+1..T+2, cpu_done_o at T+3, cpu_rdata_o = 0xDEADBEEF, dma_rdata_o = 0.
REQ-036 dma word store 0x12345678 at 0x20 -> mem_write_o high only at T+2; a subsequent cpu load at 0x20 returns 0x12345678.
REQ-037 Both requests held continuously, DMEM_ARB_RR_EN defined -> grants cpu, dma, cpu, dma every 4 cycles; macro undefined -> cpu granted every 4 cycles and dma never granted.
REQ-038 rst_i pulsed at T+1 of a cpu store -> mem_write_o never high, no done_o, busy_o = 0 at T+2, memory unchanged.
REQ-039 cpu byte load, sext = 1, from a byte of 0x80 -> cpu_rdata_o = 0xFFFFFF80; sext = 0 -> cpu_rdata_o = 0x00000080.
REQ-040 cpu_req_i raised for one cycle while state is BUSY, then dropped -> no cpu gnt_o and no access.
